// File: rtl/rv32_mem_arbiter_if.sv
// Bus bundle for the fetch port, the load/store port and the shared memory.
// The slave modport is the arbiter's view; master is the surrounding system
// (requesters plus memory).
interface rv32_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_valid;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_req_ready;
    logic              if_rsp_valid;
    logic [DATA_W-1:0] if_rsp_data;

    logic              d_req_valid;
    logic              d_req_we;
    logic [3:0]        d_req_be;
    logic [ADDR_W-1:0] d_req_addr;
    logic [DATA_W-1:0] d_req_wdata;
    logic              d_req_ready;
    logic              d_rsp_valid;
    logic [DATA_W-1:0] d_rsp_data;

    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        input  d_req_valid, d_req_we, d_req_be, d_req_addr, d_req_wdata,
        output d_req_ready, d_rsp_valid, d_rsp_data,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        output d_req_valid, d_req_we, d_req_be, d_req_addr, d_req_wdata,
        input  d_req_ready, d_rsp_valid, d_rsp_data,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/rv32_mem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous memory.
// Data port has priority; a starvation counter forces a fetch grant after
// STARVE_MAX consecutive losses. One transaction in flight at a time.
module rv32_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input logic               clk,
    input logic               reset,
    rv32_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [1:0] LAT_INIT   = 2'(MEM_LAT - 1);

    state_t            state_reg, state_next;
    logic              owner_d_reg;      // 1 = load/store port, 0 = fetch
    logic [ADDR_W-1:0] addr_reg;
    logic              we_reg;
    logic [3:0]        be_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [3:0]        starve_reg;
    logic [1:0]        lat_reg;
    logic              if_rsp_valid_reg, d_rsp_valid_reg;
    logic [DATA_W-1:0] if_rsp_data_reg, d_rsp_data_reg;

    logic              grant_d, grant_f;
    logic              issue;
    logic [3:0]        mem_we_vec;

    // Arbitration: data wins unless fetch has lost STARVE_MAX times in a row.
    assign grant_d = bus.d_req_valid && !(bus.if_req_valid && starve_reg == STARVE_LIM);
    assign grant_f = bus.if_req_valid && !grant_d;

    // Next-state logic and combinational handshake outputs.
    always_comb begin
        state_next       = state_reg;
        bus.if_req_ready = 1'b0;
        bus.d_req_ready  = 1'b0;
        issue            = 1'b0;
        case (state_reg)
            IDLE: begin
                bus.if_req_ready = grant_f;
                bus.d_req_ready  = grant_d;
                if (grant_f || grant_d) state_next = ISSUE;
            end
            ISSUE: begin
                issue      = 1'b1;
                state_next = (MEM_LAT == 1) ? RESP : WAIT;
            end
            WAIT: begin
                if (lat_reg <= 2'd1) state_next = RESP;
            end
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Byte write strobes are only live during the single issue cycle of a store.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_we
            assign mem_we_vec[gi] = issue && we_reg && be_reg[gi];
        end
    endgenerate

    assign bus.mem_en       = issue;
    assign bus.mem_we       = mem_we_vec;
    assign bus.mem_addr     = issue ? addr_reg  : '0;
    assign bus.mem_wdata    = issue ? wdata_reg : '0;
    assign bus.if_rsp_valid = if_rsp_valid_reg;
    assign bus.if_rsp_data  = if_rsp_data_reg;
    assign bus.d_rsp_valid  = d_rsp_valid_reg;
    assign bus.d_rsp_data   = d_rsp_data_reg;

    // State register, request capture, latency count, starvation and responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            owner_d_reg      <= 1'b0;
            addr_reg         <= '0;
            we_reg           <= 1'b0;
            be_reg           <= '0;
            wdata_reg        <= '0;
            starve_reg       <= '0;
            lat_reg          <= '0;
            if_rsp_valid_reg <= 1'b0;
            d_rsp_valid_reg  <= 1'b0;
            if_rsp_data_reg  <= '0;
            d_rsp_data_reg   <= '0;
        end else begin
            state_reg        <= state_next;
            if_rsp_valid_reg <= 1'b0;
            d_rsp_valid_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_d) begin
                        owner_d_reg <= 1'b1;
                        addr_reg    <= {bus.d_req_addr[ADDR_W-1:2], 2'b00};
                        we_reg      <= bus.d_req_we;
                        be_reg      <= bus.d_req_be;
                        wdata_reg   <= bus.d_req_wdata;
                        if (bus.if_req_valid && starve_reg < STARVE_LIM)
                            starve_reg <= starve_reg + 4'd1;
                    end else if (grant_f) begin
                        owner_d_reg <= 1'b0;
                        addr_reg    <= {bus.if_req_addr[ADDR_W-1:2], 2'b00};
                        we_reg      <= 1'b0;
                        be_reg      <= '0;
                        wdata_reg   <= '0;
                        starve_reg  <= '0;
                    end
                end
                ISSUE: lat_reg <= LAT_INIT;
                WAIT:  lat_reg <= lat_reg - 2'd1;
                RESP: begin
                    if (owner_d_reg) begin
                        d_rsp_valid_reg <= 1'b1;
                        d_rsp_data_reg  <= we_reg ? '0 : bus.mem_rdata;
                    end else begin
                        if_rsp_valid_reg <= 1'b1;
                        if_rsp_data_reg  <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Directed bench: one arbiter with MEM_LAT=1 and one with MEM_LAT=3, each
// attached to a small behavioural memory.
module tb_rv32_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    rv32_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
    rv32_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

    rv32_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1));
    rv32_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
        .clk(clk), .reset(reset), .bus(bus3));

    // Memory for the MEM_LAT=1 instance: read data one cycle after mem_en.
    logic [31:0] mem1 [0:4095];
    logic [31:0] rd1;
    always @(posedge clk) begin
        if (reset) begin
            mem1[12'h041] <= 32'h0010_0093;
            mem1[12'h800] <= 32'h0000_0000;
        end else if (bus1.mem_en) begin
            rd1 <= mem1[bus1.mem_addr[13:2]];
            for (int b = 0; b < 4; b++)
                if (bus1.mem_we[b]) mem1[bus1.mem_addr[13:2]][8*b +: 8] <= bus1.mem_wdata[8*b +: 8];
        end
    end
    assign bus1.mem_rdata = rd1;

    // Memory for the MEM_LAT=3 instance: three-stage read pipeline.
    logic [31:0] mem3 [0:4095];
    logic [31:0] p1, p2, p3;
    always @(posedge clk) begin
        if (reset) begin
            mem3[12'h000] <= 32'h1111_0000;
            mem3[12'h010] <= 32'hCAFE_F00D;
        end else if (bus3.mem_en) begin
            p1 <= mem3[bus3.mem_addr[13:2]];
        end
        p2 <= p1;
        p3 <= p2;
    end
    assign bus3.mem_rdata = p3;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [9:0] exp_order;
    int         ng;

    initial begin
        bus1.if_req_valid = 0; bus1.if_req_addr = 0;
        bus1.d_req_valid = 0; bus1.d_req_we = 0; bus1.d_req_be = 0;
        bus1.d_req_addr = 0; bus1.d_req_wdata = 0;
        bus3.if_req_valid = 0; bus3.if_req_addr = 0;
        bus3.d_req_valid = 0; bus3.d_req_we = 0; bus3.d_req_be = 0;
        bus3.d_req_addr = 0; bus3.d_req_wdata = 0;
        exp_order = 10'b1111011110;

        // Reset values
        tick(); tick();
        chk("rst_mem_en", bus1.mem_en, 0);
        chk("rst_mem_we", bus1.mem_we, 0);
        chk("rst_mem_addr", bus1.mem_addr, 0);
        chk("rst_if_rsp_valid", bus1.if_rsp_valid, 0);
        chk("rst_d_rsp_valid", bus1.d_rsp_valid, 0);
        chk("rst_if_rsp_data", bus1.if_rsp_data, 0);
        chk("rst_ready", {bus1.if_req_ready, bus1.d_req_ready}, 0);
        reset = 0;

        // Single fetch, MEM_LAT=1
        tick();
        bus1.if_req_valid = 1; bus1.if_req_addr = 32'h0000_0104;
        #1;
        chk("f1_if_ready_T", bus1.if_req_ready, 1);
        chk("f1_d_ready_T", bus1.d_req_ready, 0);
        tick();
        bus1.if_req_valid = 0;
        #1;
        chk("f1_mem_en_T1", bus1.mem_en, 1);
        chk("f1_mem_addr_T1", bus1.mem_addr, 32'h104);
        chk("f1_mem_we_T1", bus1.mem_we, 0);
        chk("f1_ready_T1", bus1.if_req_ready, 0);
        tick();
        chk("f1_mem_en_T2", bus1.mem_en, 0);
        chk("f1_rsp_valid_T2", bus1.if_rsp_valid, 0);
        tick();
        chk("f1_rsp_valid_T3", bus1.if_rsp_valid, 1);
        chk("f1_rsp_data_T3", bus1.if_rsp_data, 32'h0010_0093);
        chk("f1_d_rsp_valid_T3", bus1.d_rsp_valid, 0);
        tick();
        chk("f1_rsp_valid_T4", bus1.if_rsp_valid, 0);
        chk("f1_rsp_hold_T4", bus1.if_rsp_data, 32'h0010_0093);

        // Store, misaligned address, two byte lanes
        bus1.d_req_valid = 1; bus1.d_req_we = 1; bus1.d_req_be = 4'b0011;
        bus1.d_req_addr = 32'h0000_2002; bus1.d_req_wdata = 32'hDEAD_BEEF;
        #1;
        chk("st_d_ready", bus1.d_req_ready, 1);
        tick();
        bus1.d_req_valid = 0;
        #1;
        chk("st_mem_en", bus1.mem_en, 1);
        chk("st_mem_addr", bus1.mem_addr, 32'h2000);
        chk("st_mem_we", bus1.mem_we, 4'b0011);
        chk("st_mem_wdata", bus1.mem_wdata, 32'hDEAD_BEEF);
        tick();
        chk("st_mem_we_off", bus1.mem_we, 0);
        tick();
        chk("st_rsp_valid", bus1.d_rsp_valid, 1);
        chk("st_rsp_data", bus1.d_rsp_data, 0);

        // Load back, issued in the store acknowledge cycle
        bus1.d_req_valid = 1; bus1.d_req_we = 0; bus1.d_req_be = 0;
        bus1.d_req_addr = 32'h0000_2000;
        #1;
        chk("ld_d_ready", bus1.d_req_ready, 1);
        tick();
        bus1.d_req_valid = 0;
        #1;
        chk("ld_mem_en", bus1.mem_en, 1);
        chk("ld_mem_we", bus1.mem_we, 0);
        tick();
        tick();
        // Back-to-back: fetch raised during the load response pulse
        bus1.if_req_valid = 1; bus1.if_req_addr = 32'h0000_0104;
        #1;
        chk("ld_rsp_valid", bus1.d_rsp_valid, 1);
        chk("ld_rsp_data", bus1.d_rsp_data, 32'h0000_BEEF);
        chk("b2b_if_ready", bus1.if_req_ready, 1);
        chk("ld_if_data_hold", bus1.if_rsp_data, 32'h0010_0093);
        tick();
        bus1.if_req_valid = 0;
        tick();
        tick();
        chk("b2b_if_rsp_valid", bus1.if_rsp_valid, 1);
        chk("b2b_if_rsp_data", bus1.if_rsp_data, 32'h0010_0093);
        chk("b2b_d_rsp_valid", bus1.d_rsp_valid, 0);

        // Contention: both requesters held valid
        bus1.d_req_valid = 1; bus1.d_req_we = 0; bus1.d_req_addr = 32'h0000_2000;
        bus1.if_req_valid = 1; bus1.if_req_addr = 32'h0000_0104;
        ng = 0;
        for (int c = 0; c < 60 && ng < 10; c++) begin
            if (c > 0) tick();
            #1;
            if (bus1.if_req_ready || bus1.d_req_ready) begin
                chk($sformatf("grant%0d_is_d", ng), bus1.d_req_ready, exp_order[9-ng]);
                ng++;
            end
        end
        chk("grant_count", ng, 10);
        tick();
        bus1.d_req_valid = 0; bus1.if_req_valid = 0;
        tick();
        tick();

        // MEM_LAT=3 single load; fetch waits behind it
        bus3.d_req_valid = 1; bus3.d_req_we = 0; bus3.d_req_addr = 32'h0000_0040;
        #1;
        chk("l3_d_ready_T", bus3.d_req_ready, 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            bus3.d_req_valid = 0;
            bus3.if_req_valid = 1; bus3.if_req_addr = 32'h0000_0000;
            #1;
            chk($sformatf("l3_ready_T%0d", k), {bus3.if_req_ready, bus3.d_req_ready}, 0);
            chk($sformatf("l3_mem_en_T%0d", k), bus3.mem_en, (k == 1) ? 1 : 0);
            chk($sformatf("l3_rsp_valid_T%0d", k), bus3.d_rsp_valid, 0);
        end
        tick();
        chk("l3_rsp_valid_T5", bus3.d_rsp_valid, 1);
        chk("l3_rsp_data_T5", bus3.d_rsp_data, 32'hCAFE_F00D);
        chk("l3_if_ready_T5", bus3.if_req_ready, 1);
        tick();
        bus3.if_req_valid = 0;
        #1;
        chk("l3_rsp_valid_T6", bus3.d_rsp_valid, 0);
        tick(); tick(); tick();
        chk("l3_if_rsp_pre", bus3.if_rsp_valid, 0);
        tick();
        chk("l3_if_rsp_valid", bus3.if_rsp_valid, 1);
        chk("l3_if_rsp_data", bus3.if_rsp_data, 32'h1111_0000);

        // Reset during WAIT abandons the load
        tick();
        bus3.d_req_valid = 1; bus3.d_req_addr = 32'h0000_0040;
        #1;
        chk("rm_d_ready", bus3.d_req_ready, 1);
        tick();
        bus3.d_req_valid = 0;
        tick();
        reset = 1;
        #1;
        chk("rm_in_wait_mem_en", bus3.mem_en, 0);
        tick();
        reset = 0;
        chk("rm_out_mem_en", bus3.mem_en, 0);
        chk("rm_out_d_rsp_valid", bus3.d_rsp_valid, 0);
        chk("rm_out_d_rsp_data", bus3.d_rsp_data, 0);
        chk("rm_out_if_rsp_data", bus3.if_rsp_data, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rm_quiet%0d", k), {bus3.mem_en, bus3.d_rsp_valid}, 0);
        end
        bus3.d_req_valid = 1; bus3.d_req_addr = 32'h0000_0040;
        #1;
        chk("rm_new_ready", bus3.d_req_ready, 1);
        tick();
        bus3.d_req_valid = 0;
        tick(); tick(); tick();
        tick();
        chk("rm_new_rsp_valid", bus3.d_rsp_valid, 1);
        chk("rm_new_rsp_data", bus3.d_rsp_data, 32'hCAFE_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/rv32_mem_arbiter.md
Name: rv32_mem_arbiter

Overview:
- Shares one single-port synchronous memory between the priRV32 instruction-fetch port and the load/store port.
- Accepts one request at a time from either requester and sequences the memory access. Returns the response to the requester that issued it.
- Data port has priority. A starvation counter guarantees fetch forward progress.
- Sits between the core pipeline and the on-chip RAM/IO map inside the priRV32 top.

Parameters:
- ADDR_W, 32, address width of requests and memory.
- DATA_W, 32, data width. Fixed at 32; byte enables are DATA_W/8 = 4.
- MEM_LAT, 1, memory read latency in cycles from mem_en to mem_rdata valid. Legal range 1..4.
- STARVE_MAX, 4, number of consecutive lost arbitrations after which fetch is forced to win. Legal range 1..15.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req_valid  in  1  fetch request valid.
- if_req_addr  in  ADDR_W  fetch byte address.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_rsp_valid  out  1  one-cycle pulse: fetch data available.
- if_rsp_data  out  DATA_W  fetched instruction word.
- d_req_valid  in  1  load/store request valid.
- d_req_we  in  1  1 = store, 0 = load.
- d_req_be  in  4  store byte enables.
- d_req_addr  in  ADDR_W  load/store byte address.
- d_req_wdata  in  DATA_W  store data.
- d_req_ready  out  1  load/store request accepted this cycle.
- d_rsp_valid  out  1  one-cycle pulse: load data or store acknowledge.
- d_rsp_data  out  DATA_W  load data; 0 for store acknowledges.
- mem_en  out  1  memory access strobe.
- mem_we  out  4  per-byte write enables.
- mem_addr  out  ADDR_W  word address (byte address with bits [1:0] forced to 0).
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, starve counter 0, owner = fetch.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - ready is combinational and asserted only for the winning requester whose valid is high.
  - Acceptance occurs when valid & ready in cycle T. Address, we, be and wdata are registered along with the owner.
  - On acceptance go to ISSUE; with no valid request, stay in IDLE.
- ISSUE (T+1):
  - mem_en=1; mem_addr, mem_wdata driven from the registered values.
  - mem_we = be if store, else 0.
  - Go to WAIT with latency counter = MEM_LAT-1, or straight to RESP if MEM_LAT=1.
- WAIT: mem_en=0. Decrement the counter each cycle; go to RESP when it reaches 0.
- RESP (T+1+MEM_LAT):
  - Capture mem_rdata into the owner's rsp_data register; stores capture 0.
  - rsp_valid pulses in the next cycle (T+2+MEM_LAT), exactly one cycle, to the owner only.
  - Return to IDLE in that same cycle, so a new request can be accepted in the cycle rsp_valid is high.
- Latency from acceptance to rsp_valid is MEM_LAT+2 cycles. Maximum throughput is one transaction per MEM_LAT+2 cycles.
- rsp_data holds its value until the next response to the same port.
- Arbitration in IDLE:
  - If only one valid is high, that requester wins.
  - If both are high, data wins unless starve counter == STARVE_MAX, in which case fetch wins.
- Starve counter:
  - Increments when data wins while if_req_valid=1.
  - Clears on any fetch grant.
  - Holds otherwise and saturates at STARVE_MAX.
- Protocol: requesters hold valid and payload stable until ready. ready is never asserted outside IDLE. The arbiter never drops an accepted request except on reset.
- Reset mid-operation: the in-flight transaction is abandoned, with no rsp_valid and no further mem_en. Outputs return to 0 the cycle after reset is sampled high.
- Misaligned addresses: bits [1:0] are ignored with no error; alignment checking is the core's job.

Test Plan:
- Single fetch, MEM_LAT=1: if_req_valid with addr 0x0000_0104 at cycle T. Required: if_req_ready=1 at T; mem_en=1 and mem_addr=0x104 at T+1; memory returns 0x0010_0093, and if_rsp_valid=1 with if_rsp_data=0x0010_0093 at T+3 only.
- Store then load: store be=4'b0011, addr 0x2002, wdata 0xDEAD_BEEF. Required: mem_addr=0x2000 and mem_we=4'b0011 for one cycle; d_rsp_valid pulses with d_rsp_data=0. A subsequent load of 0x2000 returns the memory model value 0x0000_BEEF.
- Contention, STARVE_MAX=4: both valids held high continuously. Required grant order D,D,D,D,F,D,D,D,D,F; fetch is never starved.
- MEM_LAT=3: single load. Required: rsp_valid exactly 5 cycles after acceptance; mem_en high exactly 1 cycle; ready low for cycles T+1..T+4.
- Reset mid-operation: reset asserted for 1 cycle during WAIT. Required: no rsp_valid for the abandoned transaction; all outputs 0 after the reset cycle; the next request completes normally.
- Back-to-back: a new fetch held valid during the RESP pulse of a prior load. Required: if_req_ready=1 in the same cycle d_rsp_valid=1.
